// File: rtl/snake_engine.sv
// Snake body engine: keeps the body as a chain of 2-bit direction links, moves the head per tick
// and streams every segment coordinate (head first) after each move.
module snake_engine #(
  parameter int unsigned GRID_W   = 20,
  parameter int unsigned GRID_H   = 20,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned GROW     = 1,
  parameter int unsigned WRAP     = 0,
  localparam int unsigned XW = $clog2(GRID_W + 2),
  localparam int unsigned YW = $clog2(GRID_H + 2),
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tick,
  input  logic [1:0]    i_dir,
  input  logic          i_eat,
  output logic [1:0]    o_head_dir,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  output logic [LW-1:0] o_length,
  output logic [XW-1:0] o_pos_x,
  output logic [YW-1:0] o_pos_y,
  output logic          o_pos_valid,
  output logic          o_pos_first,
  output logic          o_pos_last,
  output logic          o_busy,
  output logic          o_failure,
  output logic          o_success
);

  localparam int unsigned IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PendMax = (1 << LW) - 1;
  localparam logic [XW-1:0] XMax  = XW'(GRID_W + 1);
  localparam logic [YW-1:0] YMax  = YW'(GRID_H + 1);
  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);
  localparam logic [LW-1:0] GrowC  = (GROW > PendMax) ? LW'(PendMax) : LW'(GROW);

  typedef enum logic {StScan, StWait} state_e;

  state_e        state;
  logic [LW-1:0] idx;
  logic [LW-1:0] pending;
  logic          pend_tick;
  logic [1:0]    link [MAX_LEN];

  logic [1:0]    mv_dir;
  logic [XW-1:0] nx, seg_x;
  logic [YW-1:0] ny, seg_y;
  logic          do_move, grow, wall, last;
  logic [LW-1:0] pend_after, pend_next, len_next;
  logic [LW:0]   pend_sum;

  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input logic [1:0] d);
    logic [XW-1:0] r;
    r = x;
    if (d == 2'b10) r = x + XW'(1);
    else if (d == 2'b11) r = x - XW'(1);
    if (WRAP != 0) begin
      if (r == XMax) r = XW'(1);
      else if (r == '0) r = XW'(GRID_W);
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input logic [1:0] d);
    logic [YW-1:0] r;
    r = y;
    if (d == 2'b00) r = y + YW'(1);
    else if (d == 2'b01) r = y - YW'(1);
    if (WRAP != 0) begin
      if (r == YMax) r = YW'(1);
      else if (r == '0) r = YW'(GRID_H);
    end
    return r;
  endfunction

  always_comb begin
    mv_dir = i_dir;
    if (i_dir == (o_head_dir ^ 2'b01)) mv_dir = o_head_dir;
    nx = step_x(o_head_x, mv_dir);
    ny = step_y(o_head_y, mv_dir);
    do_move = (state == StWait) && (i_tick || pend_tick) && !o_failure && !o_success;
    grow = do_move && (pending != '0) && (o_length < MaxLen);
    // Growth for this move is decided before a coincident eat is folded in.
    pend_after = pending - LW'(grow);
    pend_sum = {1'b0, pend_after} + {1'b0, GrowC};
    pend_next = pend_after;
    if (i_eat) pend_next = pend_sum[LW] ? '1 : pend_sum[LW-1:0];
    len_next = o_length + LW'(grow);
    wall = (WRAP == 0) && (nx == '0 || nx == XMax || ny == '0 || ny == YMax);
    seg_x = o_head_x;
    seg_y = o_head_y;
    if (idx != '0) begin
      seg_x = step_x(o_pos_x, link[IW'(idx - LW'(1))]);
      seg_y = step_y(o_pos_y, link[IW'(idx - LW'(1))]);
    end
    last = (idx == o_length - LW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StScan;
      idx         <= '0;
      pending     <= '0;
      pend_tick   <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) link[k] <= 2'b01;
      o_head_dir  <= 2'b00;
      o_head_x    <= XW'(GRID_W / 2);
      o_head_y    <= YW'(GRID_H / 2);
      o_length    <= LW'(INIT_LEN);
      o_pos_x     <= '0;
      o_pos_y     <= '0;
      o_pos_valid <= 1'b0;
      o_pos_first <= 1'b0;
      o_pos_last  <= 1'b0;
      o_busy      <= 1'b1;
      o_failure   <= 1'b0;
      o_success   <= 1'b0;
    end else begin
      o_busy      <= (state == StScan) | pend_tick;
      o_pos_valid <= 1'b0;
      o_pos_first <= 1'b0;
      o_pos_last  <= 1'b0;
      pending     <= pend_next;
      o_length    <= len_next;
      if (len_next == MaxLen) o_success <= 1'b1;
      case (state)
        StScan: begin
          o_pos_x     <= seg_x;
          o_pos_y     <= seg_y;
          o_pos_valid <= 1'b1;
          o_pos_first <= (idx == '0);
          o_pos_last  <= last;
          if (idx != '0 && seg_x == o_head_x && seg_y == o_head_y) o_failure <= 1'b1;
          if (i_tick) pend_tick <= 1'b1;
          if (last) begin
            state <= StWait;
            idx   <= '0;
          end else begin
            idx <= idx + LW'(1);
          end
        end
        default: begin
          pend_tick <= 1'b0;
          if (do_move) begin
            o_head_x   <= nx;
            o_head_y   <= ny;
            o_head_dir <= mv_dir;
            for (int k = 1; k < MAX_LEN; k++) link[k] <= link[k-1];
            link[0] <= mv_dir ^ 2'b01;
            state   <= StScan;
            idx     <= '0;
            if (wall) o_failure <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: expected streams are queued by the stimulus process and
// checked by an independent monitor; three instances cover wall, wrap and growth/success.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       eat = 1'b0;
  logic [1:0] dir = 2'b00;

  always #5 clk = ~clk;

  logic [1:0] a_dir, w_dir, g_dir;
  logic [4:0] a_hx, a_hy, a_px, a_py, w_hx, w_hy, w_px, w_py, g_hx, g_hy, g_px, g_py;
  logic [5:0] a_len, w_len;
  logic [2:0] g_len;
  logic a_valid, a_first, a_last, a_busy, a_fail, a_succ;
  logic w_valid, w_first, w_last, w_busy, w_fail, w_succ;
  logic g_valid, g_first, g_last, g_busy, g_fail, g_succ;

  snake_engine u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_dir(dir), .i_eat(eat),
    .o_head_dir(a_dir), .o_head_x(a_hx), .o_head_y(a_hy), .o_length(a_len),
    .o_pos_x(a_px), .o_pos_y(a_py), .o_pos_valid(a_valid), .o_pos_first(a_first),
    .o_pos_last(a_last), .o_busy(a_busy), .o_failure(a_fail), .o_success(a_succ)
  );

  snake_engine #(.WRAP(1)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_dir(dir), .i_eat(eat),
    .o_head_dir(w_dir), .o_head_x(w_hx), .o_head_y(w_hy), .o_length(w_len),
    .o_pos_x(w_px), .o_pos_y(w_py), .o_pos_valid(w_valid), .o_pos_first(w_first),
    .o_pos_last(w_last), .o_busy(w_busy), .o_failure(w_fail), .o_success(w_succ)
  );

  snake_engine #(.MAX_LEN(6), .GROW(2)) u_dut_g (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_dir(dir), .i_eat(eat),
    .o_head_dir(g_dir), .o_head_x(g_hx), .o_head_y(g_hy), .o_length(g_len),
    .o_pos_x(g_px), .o_pos_y(g_py), .o_pos_valid(g_valid), .o_pos_first(g_first),
    .o_pos_last(g_last), .o_busy(g_busy), .o_failure(g_fail), .o_success(g_succ)
  );

  typedef struct {int x; int y; int f; int l;} seg_t;
  seg_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   sb_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_scan(input int n, input int xs[5], input int ys[5]);
    seg_t s;
    for (int i = 0; i < n; i++) begin
      s.x = xs[i];
      s.y = ys[i];
      s.f = (i == 0) ? 1 : 0;
      s.l = (i == n - 1) ? 1 : 0;
      sbq.push_back(s);
    end
  endtask

  // Stream monitor for instance a.
  seg_t e;
  always @(negedge clk) begin
    if (sb_en && a_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stream_extra: got segment (%0d,%0d), expected no segment", a_px, a_py);
      end else begin
        e = sbq.pop_front();
        chk("stream_x", int'(a_px), e.x);
        chk("stream_y", int'(a_py), e.y);
        chk("stream_first", int'(a_first), e.f);
        chk("stream_last", int'(a_last), e.l);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((a_busy | w_busy | g_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy still 1 after 200 cycles, expected 0");
    end
  endtask

  task automatic do_tick(input logic [1:0] d);
    wait_idle();
    dir  = d;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_eat();
    wait_idle();
    eat = 1'b1;
    @(negedge clk);
    eat = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 1: reset stream, moves, reversal, growth, self-collision.
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_busy", int'(a_busy), 1);
    chk("rst_head_x", int'(a_hx), 10);
    chk("rst_head_y", int'(a_hy), 10);
    chk("rst_length", int'(a_len), 4);
    chk("rst_head_dir", int'(a_dir), 0);
    chk("rst_failure", int'(a_fail), 0);
    chk("rst_success", int'(a_succ), 0);
    sb_en = 1'b1;
    push_scan(4, '{10, 10, 10, 10, 0}, '{10, 9, 8, 7, 0});
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("busy_cycle%0d", c), int'(a_busy), (c < 5) ? 1 : 0);
    end

    push_scan(4, '{11, 10, 10, 10, 0}, '{10, 10, 9, 8, 0});
    do_tick(2'b10);
    chk("m1_head_x", int'(a_hx), 11);
    chk("m1_head_y", int'(a_hy), 10);
    chk("m1_length", int'(a_len), 4);

    push_scan(4, '{12, 11, 10, 10, 0}, '{10, 10, 10, 9, 0});
    do_tick(2'b11);
    chk("rev_head_x", int'(a_hx), 12);
    chk("rev_head_dir", int'(a_dir), 2);

    do_eat();
    push_scan(5, '{13, 12, 11, 10, 10}, '{10, 10, 10, 10, 9});
    do_tick(2'b10);
    chk("grow_length", int'(a_len), 5);

    push_scan(5, '{13, 13, 12, 11, 10}, '{9, 10, 10, 10, 10});
    do_tick(2'b01);
    push_scan(5, '{12, 13, 13, 12, 11}, '{9, 9, 10, 10, 10});
    do_tick(2'b11);
    wait_idle();
    chk("pre_collide_failure", int'(a_fail), 0);
    push_scan(5, '{12, 12, 13, 13, 12}, '{10, 9, 9, 10, 10});
    do_tick(2'b00);
    wait_idle();
    chk("collide_failure", int'(a_fail), 1);

    do_tick(2'b10);
    chk("dead_head_x", int'(a_hx), 12);
    chk("dead_head_y", int'(a_hy), 10);
    repeat (8) @(negedge clk);
    chk("p1_queue_empty", sbq.size(), 0);
    sb_en = 1'b0;

    // Phase 2: one-deep tick buffering, then walls vs wrap.
    do_reset();
    sb_en = 1'b1;
    push_scan(4, '{10, 10, 10, 10, 0}, '{10, 9, 8, 7, 0});
    push_scan(4, '{11, 10, 10, 10, 0}, '{10, 10, 9, 8, 0});
    rst_n = 1'b1;
    dir = 2'b10;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_idle();
    chk("pend_head_x", int'(a_hx), 11);
    chk("pend_head_dir", int'(a_dir), 2);
    repeat (3) @(negedge clk);
    chk("p2_queue_empty", sbq.size(), 0);
    sb_en = 1'b0;

    for (int i = 0; i < 9; i++) do_tick(2'b10);
    wait_idle();
    chk("edge_head_x_a", int'(a_hx), 20);
    chk("edge_head_x_w", int'(w_hx), 20);
    chk("edge_failure_a", int'(a_fail), 0);
    do_tick(2'b10);
    chk("wall_failure", int'(a_fail), 1);
    chk("wall_head_x", int'(a_hx), 21);
    chk("wrap_head_x", int'(w_hx), 1);
    chk("wrap_head_y", int'(w_hy), 10);
    chk("wrap_failure", int'(w_fail), 0);

    // Phase 3: growth of 2 per eat up to MAX_LEN=6 gives success.
    do_reset();
    rst_n = 1'b1;
    do_eat();
    do_tick(2'b10);
    chk("g_length_5", int'(g_len), 5);
    chk("g_success_early", int'(g_succ), 0);
    do_tick(2'b10);
    chk("g_length_6", int'(g_len), 6);
    chk("g_success", int'(g_succ), 1);
    do_tick(2'b10);
    chk("g_frozen_head_x", int'(g_hx), 12);
    chk("a_success", int'(a_succ), 0);
    chk("a_length", int'(a_len), 5);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
